axi_stream_packet_arb: RTL and testbench
========================================

# axi_stream_packet_arb

Packet-aware round-robin arbiter that shares one AXI-stream output between NUM_IN AXI-stream sources. Once a packet is granted (on .sop), the output stays locked to that source until the beat carrying .eop is accepted, so packets are never interleaved. Its main use is to merge per-core result streams, such as hash and EC engines, onto the single host return channel. One registered output stage gives full throughput with a single cycle of latency.

## Interface
- NUM_IN, 4: number of requesting input streams, 2..16
- DAT_BYTS, 8: data bytes per beat, identical on all inputs and the output
- CTL_BITS, 8: ctl field width
- MOD_BITS, DAT_BYTS==1 ? 1 : $clog2(DAT_BYTS): mod field width
- IDX_IN_CTL, 1: when 1, ctl[$clog2(NUM_IN)-1:0] on the output is overwritten with the granted input index; requires CTL_BITS >= $clog2(NUM_IN)

Ports:
- i_clk  in  1  single clock for all logic
- i_rst  in  1  asynchronous, active-high reset
- i_axi  if_axi_stream.sink [NUM_IN]  requesting streams; rdy driven by this block
- o_axi  if_axi_stream.source  merged stream; rdy driven by the downstream
- o_grant  out  $clog2(NUM_IN)  index of the currently or last granted input
- o_locked  out  1  high while a multi-beat packet is in progress
- o_drop  out  1  one-cycle pulse when an orphan beat (val without sop while idle) is discarded

## Operation
- State machine IDLE / LOCKED, plus a round-robin pointer ptr (range 0..NUM_IN-1).
- Output stage: a single register holding {val, sop, eop, err, mod, ctl, dat}. It is free when !o_axi.val || o_axi.rdy.
- IDLE, arbitration:
  - Candidates are inputs with val && sop.
  - Winner is the first candidate searching ptr, ptr+1, ... modulo NUM_IN.
  - If the output stage is free: assert rdy on the winner only and accept its beat. Set o_grant = winner and ptr = winner+1 (mod NUM_IN).
  - If the accepted beat has !eop, move to LOCKED. A single-beat packet (sop && eop) stays in IDLE.
- IDLE, orphans:
  - An input with val && !sop is drained: rdy=1 and the beat is discarded. o_drop pulses once per discarded beat.
  - Draining happens in the same cycle as arbitration and does not involve the output stage.
- LOCKED:
  - Only i_axi[o_grant].rdy can be high; it equals "output stage free".
  - Each accepted beat is copied into the output stage.
  - The accepted beat with eop returns the state to IDLE. ptr is already advanced.
  - A sop seen mid-packet on the granted input is passed through unchanged and does not restart arbitration.
- All other inputs have rdy=0, except orphan draining in IDLE.
- ctl:
  - With IDX_IN_CTL=1, the low $clog2(NUM_IN) bits are replaced by the grant index and the upper bits pass through.
  - With IDX_IN_CTL=0, ctl passes through untouched.
- err and mod pass through unmodified.

## Timing
- Latency: an input beat accepted at edge N appears on o_axi at N+1 (val registered).
- Throughput: one beat per cycle while o_axi.rdy=1. Switching from one input's eop to the next input's sop costs no bubble.
- Each input rdy is combinational from o_axi.rdy, state, ptr and the input val/sop. There is no combinational path from i_axi.dat to any rdy.
- Backpressure: while o_axi.val && !o_axi.rdy, the output register holds and every rdy is 0. The only exception is orphan draining in IDLE.
- Simultaneous sop on all inputs with ptr=0: grants in the order 0, 1, 2, 3, 0, ...
- Reset (asynchronous, at any time, including mid-packet):
  - o_axi.val/sop/eop/err/mod/ctl/dat = 0, o_grant=0, o_locked=0, o_drop=0, state=IDLE, ptr=0.
  - Every rdy is 0 while i_rst is high.
  - The partially forwarded packet is truncated. The downstream is expected to be reset as well.

## Test plan
- Single source: input 2 sends a 3-beat packet (dat 0x11, 0x22, 0x33, mod=5 on eop) with o_axi.rdy=1. o_axi shows the three beats on consecutive cycles, one cycle after input, with sop on beat 1, eop+mod=5 on beat 3, and ctl[1:0]=2. o_locked is high for 2 cycles.
- Fairness: all 4 inputs continuously offer 2-beat packets. Output packet sources run 0, 1, 2, 3, 0, 1, ... with no idle cycles between packets.
- Backpressure: a random 50% o_axi.rdy during a 4-input contention run of 100 packets. Every packet arrives intact and unreordered per source, and no beat is duplicated or lost (scoreboard).
- No interleave: input 1 starts a 5-beat packet, then input 0 raises sop on cycle 2. Input 0 is not granted until the cycle after input 1's eop is accepted.
- Orphan: input 3 drives val=1, sop=0, dat=0xDEAD while idle. Result: one o_drop pulse, nothing on o_axi, and input 3 rdy=1 for that cycle.
- Reset mid-packet: assert i_rst asynchronously during beat 2 of 4. Outputs clear immediately without waiting for a clock edge, and all rdy=0. After release, input 0 is granted first even if ptr was 3.

Source files
------------

// File: rtl/axi_stream_packet_arb_if.sv
// AXI-stream style bundle: val/rdy handshake with packet framing (sop/eop),
// error flag, last-beat byte modulo, control side-band and data.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
);
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [MOD_BITS-1:0]   mod;
    logic [CTL_BITS-1:0]   ctl;
    logic [DAT_BYTS*8-1:0] dat;

    modport source (output val, sop, eop, err, mod, ctl, dat, input  rdy);
    modport sink   (input  val, sop, eop, err, mod, ctl, dat, output rdy);
endinterface

// File: rtl/axi_stream_packet_arb.sv
// Packet-aware round-robin arbiter merging NUM_IN AXI-stream sources onto one
// registered output; a granted packet owns the output until its eop beat.
module axi_stream_packet_arb #(
    parameter int NUM_IN     = 4,
    parameter int DAT_BYTS   = 8,
    parameter int CTL_BITS   = 8,
    parameter int MOD_BITS   = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
    parameter bit IDX_IN_CTL = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    if_axi_stream.sink                i_axi [NUM_IN],
    if_axi_stream.source              o_axi,
    output logic [$clog2(NUM_IN)-1:0] o_grant,
    output logic                      o_locked,
    output logic                      o_drop
);
    localparam int                 IDX_W    = $clog2(NUM_IN);
    localparam int                 DAT_W    = DAT_BYTS * 8;
    localparam logic [IDX_W:0]     NUM_W    = (IDX_W + 1)'(NUM_IN);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_IN - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;

    logic [NUM_IN-1:0]   in_val, in_sop, in_eop, in_err, in_rdy;
    logic [MOD_BITS-1:0] in_mod [NUM_IN];
    logic [CTL_BITS-1:0] in_ctl [NUM_IN];
    logic [DAT_W-1:0]    in_dat [NUM_IN];

    logic                vld_p0, sop_p0, eop_p0, err_p0;
    logic [MOD_BITS-1:0] mod_p0;
    logic [CTL_BITS-1:0] ctl_p0;
    logic [DAT_W-1:0]    dat_p0;

    logic                out_free;
    logic                win_vld;
    logic [IDX_W-1:0]    win;
    logic [IDX_W:0]      cand;
    logic [NUM_IN-1:0]   orphan;
    logic                acc;
    logic [IDX_W-1:0]    sel;
    logic [CTL_BITS-1:0] ctl_sel, ctl_mux;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign in_val[g]    = i_axi[g].val;
        assign in_sop[g]    = i_axi[g].sop;
        assign in_eop[g]    = i_axi[g].eop;
        assign in_err[g]    = i_axi[g].err;
        assign in_mod[g]    = i_axi[g].mod;
        assign in_ctl[g]    = i_axi[g].ctl;
        assign in_dat[g]    = i_axi[g].dat;
        assign i_axi[g].rdy = in_rdy[g];
    end

    assign out_free = !vld_p0 || o_axi.rdy;

    // Search ptr, ptr+1, ... for the first input offering a packet start.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!win_vld && in_val[cand[IDX_W-1:0]] && in_sop[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win     = cand[IDX_W-1:0];
            end
        end
    end

    // Orphans bypass the output stage entirely, so they drain even under backpressure.
    assign orphan = (state_q == ST_IDLE && !i_rst) ? (in_val & ~in_sop) : '0;
    assign o_drop = |orphan;

    always_comb begin
        in_rdy  = '0;
        acc     = 1'b0;
        sel     = grant_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (!i_rst) begin
            if (state_q == ST_IDLE) begin
                in_rdy = orphan;
                if (win_vld && out_free) begin
                    in_rdy[win] = 1'b1;
                    acc         = 1'b1;
                    sel         = win;
                    grant_d     = win;
                    ptr_d       = (win == LAST_IDX) ? '0 : win + 1'b1;
                    if (!in_eop[win]) begin
                        state_d = ST_LOCKED;
                    end
                end
            end else begin
                in_rdy[grant_q] = out_free;
                acc             = out_free && in_val[grant_q];
                if (acc && in_eop[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    assign ctl_sel = in_ctl[sel];

    if (IDX_IN_CTL) begin : g_ctl_idx
        always_comb begin
            ctl_mux            = ctl_sel;
            ctl_mux[IDX_W-1:0] = sel;
        end
    end else begin : g_ctl_pass
        assign ctl_mux = ctl_sel;
    end

    // p0: single output register stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            vld_p0  <= 1'b0;
            sop_p0  <= 1'b0;
            eop_p0  <= 1'b0;
            err_p0  <= 1'b0;
            mod_p0  <= '0;
            ctl_p0  <= '0;
            dat_p0  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            if (out_free) begin
                vld_p0 <= acc;
                if (acc) begin
                    sop_p0 <= in_sop[sel];
                    eop_p0 <= in_eop[sel];
                    err_p0 <= in_err[sel];
                    mod_p0 <= in_mod[sel];
                    ctl_p0 <= ctl_mux;
                    dat_p0 <= in_dat[sel];
                end
            end
        end
    end

    assign o_axi.val = vld_p0;
    assign o_axi.sop = sop_p0;
    assign o_axi.eop = eop_p0;
    assign o_axi.err = err_p0;
    assign o_axi.mod = mod_p0;
    assign o_axi.ctl = ctl_p0;
    assign o_axi.dat = dat_p0;
    assign o_grant   = grant_q;
    assign o_locked  = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_axi_stream_packet_arb.sv
// Scoreboard bench for axi_stream_packet_arb: per-input drivers, per-source
// expected queues and an output monitor that pops on every accepted beat.
module tb_axi_stream_packet_arb;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [7:0]  ctl;
        logic [63:0] dat;
    } beat_t;

    logic       clk;
    logic       i_rst;
    logic       out_rdy;
    logic [1:0] o_grant;
    logic       o_locked;
    logic       o_drop;
    logic [3:0] tb_rdy;

    int vectors;
    int miscompares;
    int cyc;
    bit chk_lat;
    bit bp_rand;

    beat_t src_q [4][$];
    beat_t exp_q [4][$];
    int    lat_q [4][$];
    int    ord_q [$];
    beat_t drv_beat [4];
    logic  drv_val [4];
    logic  drv_acc [4];
    int    sop_edge [4];
    int    eop_edge [4];

    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8), .MOD_BITS(3)) in_if [4] ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8), .MOD_BITS(3)) out_if ();

    axi_stream_packet_arb #(
        .NUM_IN(4), .DAT_BYTS(8), .CTL_BITS(8), .MOD_BITS(3), .IDX_IN_CTL(1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_axi   (in_if),
        .o_axi   (out_if),
        .o_grant (o_grant),
        .o_locked(o_locked),
        .o_drop  (o_drop)
    );

    assign out_if.rdy = out_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_rdy = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign in_if[g].val = drv_val[g];
        assign in_if[g].sop = drv_beat[g].sop;
        assign in_if[g].eop = drv_beat[g].eop;
        assign in_if[g].err = drv_beat[g].err;
        assign in_if[g].mod = drv_beat[g].mod;
        assign in_if[g].ctl = drv_beat[g].ctl;
        assign in_if[g].dat = drv_beat[g].dat;
        assign tb_rdy[g]    = in_if[g].rdy;

        initial begin
            drv_val[g]  = 1'b0;
            drv_beat[g] = '0;
            drv_acc[g]  = 1'b0;
            sop_edge[g] = -1;
            eop_edge[g] = -1;
            forever begin
                @(posedge clk);
                #1;
                if (drv_acc[g] && src_q[g].size() > 0) void'(src_q[g].pop_front());
                drv_acc[g] = 1'b0;
                if (src_q[g].size() > 0) begin
                    drv_val[g]  = 1'b1;
                    drv_beat[g] = src_q[g][0];
                end else begin
                    drv_val[g] = 1'b0;
                end
                @(negedge clk);
                drv_acc[g] = drv_val[g] && tb_rdy[g];
                if (drv_acc[g]) begin
                    if (drv_beat[g].sop) sop_edge[g] = cyc + 1;
                    if (drv_beat[g].eop) eop_edge[g] = cyc + 1;
                    if (chk_lat) lat_q[g].push_back(cyc + 1);
                end
            end
        end
    end

    // Output monitor: the source is recovered from the overwritten ctl index bits.
    initial begin
        beat_t got, ex;
        int    src;
        forever begin
            @(negedge clk);
            if (out_if.val && out_rdy) begin
                got = {out_if.sop, out_if.eop, out_if.err, out_if.mod, out_if.ctl, out_if.dat};
                src = int'(got.ctl[1:0]);
                if (exp_q[src].size() == 0) begin
                    chk("unexpected_beat", 128'(got), 128'(0));
                end else begin
                    ex = exp_q[src].pop_front();
                    chk("beat", 128'(got), 128'(ex));
                end
                if (got.sop && ord_q.size() > 0) chk("grant_order", 128'(src), 128'(ord_q.pop_front()));
                if (chk_lat && lat_q[src].size() > 0) chk("latency", 128'(cyc), 128'(lat_q[src].pop_front()));
            end
        end
    end

    task automatic push(input int s, input beat_t bt, input bit expect_out);
        beat_t e;
        src_q[s].push_back(bt);
        if (expect_out) begin
            e          = bt;
            e.ctl[1:0] = 2'(s);
            exp_q[s].push_back(e);
        end
    endtask

    task automatic send_pkt(input int s, input int n, input logic [7:0] tag);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.sop = (b == 0);
            bt.eop = (b == n - 1);
            bt.err = bt.eop & tag[0];
            bt.mod = 3'(tag + 8'(b));
            bt.ctl = {tag[5:0], ~2'(s)};
            bt.dat = {8'(s), tag, 8'(b), tag ^ 8'hA5, 32'hC0DE_0000 + 32'(b)};
            push(s, bt, 1'b1);
        end
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < 4; i++) t += exp_q[i].size() + src_q[i].size();
        return t;
    endfunction

    task automatic drain(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pending() == 0) break;
        end
        repeat (2) @(negedge clk);
        chk(nm, 128'(pending()), 128'(0));
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            lat_q[i].delete();
        end
        ord_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, nval, nlock;
        beat_t bt;
        vectors     = 0;
        miscompares = 0;
        chk_lat     = 1'b0;
        bp_rand     = 1'b0;
        i_rst       = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_val", 128'(out_if.val), 128'(0));
        chk("rst_grant", 128'(o_grant), 128'(0));
        chk("rst_locked", 128'(o_locked), 128'(0));
        chk("rst_drop", 128'(o_drop), 128'(0));
        chk("rst_rdy", 128'(tb_rdy), 128'(0));
        #2 i_rst = 1'b0;
        @(negedge clk);

        // Fairness: all four inputs start together, two 2-beat packets each
        chk_lat = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++) begin
                send_pkt(s, 2, 8'(16 * p + s));
                ord_q.push_back(s);
            end
        first = -1; last = -1; nval = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_if.val) begin
                nval++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("fair_beats", 128'(nval), 128'(16));
        chk("fair_no_bubble", 128'(last - first + 1), 128'(16));
        drain("fair_drain", 20);
        chk("fair_order_done", 128'(ord_q.size()), 128'(0));

        // Single source: input 2, three beats 0x11/0x22/0x33, mod=5 on eop
        bt = '0; bt.sop = 1'b1; bt.ctl = 8'h5D; bt.dat = 64'h11; push(2, bt, 1'b1);
        bt = '0; bt.ctl = 8'h5D; bt.dat = 64'h22; push(2, bt, 1'b1);
        bt = '0; bt.eop = 1'b1; bt.mod = 3'd5; bt.ctl = 8'h5D; bt.dat = 64'h33; push(2, bt, 1'b1);
        first = -1; last = -1; nval = 0; nlock = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_locked) nlock++;
            if (out_if.val) begin
                nval++;
                if (first < 0) first = cyc;
                last = cyc;
                chk("single_ctl", 128'(out_if.ctl), 128'(8'h5E));
            end
        end
        chk("single_beats", 128'(nval), 128'(3));
        chk("single_consec", 128'(last - first + 1), 128'(3));
        chk("single_locked_cycles", 128'(nlock), 128'(2));
        chk("single_grant", 128'(o_grant), 128'(2));
        drain("single_drain", 10);

        // No interleave: input 1 sends 5 beats, input 0 raises sop two cycles in
        send_pkt(1, 5, 8'h30);
        ord_q.push_back(1);
        repeat (2) @(negedge clk);
        send_pkt(0, 2, 8'h31);
        ord_q.push_back(0);
        @(negedge clk);
        chk("nointlv_rdy0", 128'(tb_rdy[0]), 128'(0));
        chk("nointlv_grant", 128'(o_grant), 128'(1));
        chk("nointlv_locked", 128'(o_locked), 128'(1));
        drain("nointlv_drain", 20);
        chk("nointlv_handover", 128'(sop_edge[0]), 128'(eop_edge[1] + 1));

        // Orphan on input 3 while idle
        chk_lat = 1'b0;
        flush_all();
        bt = '0; bt.dat = 64'hDEAD; bt.ctl = 8'h03;
        push(3, bt, 1'b0);
        @(negedge clk);
        chk("orphan_rdy", 128'(tb_rdy), 128'(4'b1000));
        chk("orphan_drop", 128'(o_drop), 128'(1));
        chk("orphan_out_val", 128'(out_if.val), 128'(0));
        @(negedge clk);
        chk("orphan_drop_once", 128'(o_drop), 128'(0));
        chk("orphan_out_idle", 128'(out_if.val), 128'(0));
        drain("orphan_drain", 5);

        // Backpressure: 100 packets from four contending inputs, random out rdy
        bp_rand = 1'b1;
        for (int k = 0; k < 100; k++) send_pkt(k % 4, (k / 4) % 4 + 1, 8'(k));
        drain("bp_drain", 4000);
        bp_rand = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-packet: input 2 leaves ptr at 3, reset lands during beat 2 of 4
        send_pkt(2, 4, 8'h50);
        repeat (2) @(negedge clk);
        chk("midrst_pre_grant", 128'(o_grant), 128'(2));
        chk("midrst_pre_locked", 128'(o_locked), 128'(1));
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_val", 128'(out_if.val), 128'(0));
        chk("midrst_dat", 128'({out_if.sop, out_if.eop, out_if.err, out_if.mod, out_if.ctl, out_if.dat}), 128'(0));
        chk("midrst_locked", 128'(o_locked), 128'(0));
        chk("midrst_grant", 128'(o_grant), 128'(0));
        chk("midrst_rdy", 128'(tb_rdy), 128'(0));
        flush_all();
        repeat (2) @(negedge clk);
        chk("midrst_hold_val", 128'(out_if.val), 128'(0));
        #2 i_rst = 1'b0;
        @(negedge clk);
        send_pkt(3, 1, 8'h61);
        send_pkt(0, 1, 8'h60);
        ord_q.push_back(0);
        ord_q.push_back(3);
        drain("midrst_drain", 10);
        chk("midrst_order_done", 128'(ord_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
